// File: rtl/box_pkg.sv
// -----------------------------------------------------------------------------
// box_pkg
// Shared definitions for the two-port box register file arbiter:
//   BOX_DATA_W / BOX_ADDR_W : default data and address widths of the box
//   box_state_e             : arbiter FSM states
//   box_cmd_t               : one latched requester command {we, addr, wdata}
//   rr_winner()             : 2-way round-robin winner selection
// -----------------------------------------------------------------------------
package box_pkg;

  localparam int BOX_DATA_W = 8;
  localparam int BOX_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } box_state_e;

  typedef struct packed {
    logic                  we;
    logic [BOX_ADDR_W-1:0] addr;
    logic [BOX_DATA_W-1:0] wdata;
  } box_cmd_t;

  // With both ports requesting the priority port wins; otherwise the single
  // requester wins. With no request the result is 0 and is not used.
  function automatic logic rr_winner(input logic [1:0] req, input logic prio);
    logic win;
    if (req == 2'b11) begin
      win = prio;
    end else begin
      win = req[1];
    end
    return win;
  endfunction

endpackage

// File: rtl/box_rr_pick.sv
// -----------------------------------------------------------------------------
// box_rr_pick
// Combinational 2-way round-robin picker.
//   req    in  2  request vector {req1, req0}
//   prio   in  1  port that wins when both request
//   grant  out 2  one-hot grant, 0 when nobody requests
//   winner out 1  index of the granted port
// -----------------------------------------------------------------------------
module box_rr_pick
  import box_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       winner
);

  // Pick the winning port and form the one-hot grant
  always_comb begin
    winner = rr_winner(req, prio);
    if (req != 2'b00) begin
      grant = winner ? 2'b10 : 2'b01;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/box_arbiter.sv
// -----------------------------------------------------------------------------
// box_arbiter
// Shares one 4x8 box register file between two requesters with round-robin
// arbitration. Each requester issues a single read or write through a req/ack
// handshake; the arbiter drives the box pins, captures read data when the box
// raises read_active, and acks the owner. A read that never sees read_active
// within RD_TIMEOUT cycles completes with err set and rdata forced to 0.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req/we/addr/wdata 0,1     requester commands (held until ack)
//   ack/rdata/err 0,1         completion pulse, read data, timeout flag
//   box_read_enable,
//   box_write_enable,
//   box_write_data,
//   box_address               box control/data pins
//   box_read_data,
//   box_read_active           box read return
//   busy                      arbiter not idle
// All outputs are registered: every *_nx_s value is the content the output
// shows in the cycle after the current edge.
// -----------------------------------------------------------------------------
module box_arbiter
  import box_pkg::*;
#(
  parameter int DATA_W     = BOX_DATA_W,
  parameter int ADDR_W     = BOX_ADDR_W,
  parameter int RD_TIMEOUT = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              box_read_enable,
  output logic              box_write_enable,
  output logic [DATA_W-1:0] box_write_data,
  output logic [ADDR_W-1:0] box_address,
  input  logic [DATA_W-1:0] box_read_data,
  input  logic              box_read_active,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  box_state_e        state_r, state_nx_s;
  logic              owner_r, owner_nx_s;
  logic              prio_r, prio_nx_s;
  box_cmd_t          cmd_r, cmd_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;

  logic              ack0_r, ack0_nx_s, ack1_r, ack1_nx_s;
  logic              err0_r, err0_nx_s, err1_r, err1_nx_s;
  logic [DATA_W-1:0] rdata0_r, rdata0_nx_s, rdata1_r, rdata1_nx_s;
  logic              box_re_r, box_re_nx_s, box_we_r, box_we_nx_s;
  logic [DATA_W-1:0] box_wd_r, box_wd_nx_s;
  logic [ADDR_W-1:0] box_addr_r, box_addr_nx_s;
  logic              busy_r, busy_nx_s;

  box_cmd_t          cmd0_s, cmd1_s;
  logic [1:0]        grant_s;
  logic              winner_s;

  assign cmd0_s = '{we: we0, addr: addr0, wdata: wdata0};
  assign cmd1_s = '{we: we1, addr: addr1, wdata: wdata1};

  box_rr_pick u_pick (
    .req    ({req1, req0}),
    .prio   (prio_r),
    .grant  (grant_s),
    .winner (winner_s)
  );

  // Next-state and next-output logic of the transaction FSM
  always_comb begin
    state_nx_s  = state_r;
    owner_nx_s  = owner_r;
    prio_nx_s   = prio_r;
    cmd_nx_s    = cmd_r;
    cnt_nx_s    = cnt_r;
    ack0_nx_s   = 1'b0;
    ack1_nx_s   = 1'b0;
    err0_nx_s   = 1'b0;
    err1_nx_s   = 1'b0;
    rdata0_nx_s = rdata0_r;
    rdata1_nx_s = rdata1_r;

    case (state_r)
      IDLE: begin
        if (grant_s != 2'b00) begin
          state_nx_s = ISSUE;
          owner_nx_s = winner_s;
          cmd_nx_s   = winner_s ? cmd1_s : cmd0_s;
          cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_nx_s = {CNT_W{1'b0}};
        if (cmd_r.we) begin
          // The box commits the write on the edge leaving ISSUE.
          state_nx_s = DONE;
          if (owner_r) begin
            ack1_nx_s = 1'b1;
          end else begin
            ack0_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (box_read_active) begin
          state_nx_s = DONE;
          if (owner_r) begin
            ack1_nx_s   = 1'b1;
            rdata1_nx_s = box_read_data;
          end else begin
            ack0_nx_s   = 1'b1;
            rdata0_nx_s = box_read_data;
          end
        end else if (cnt_r == CNT_LAST) begin
          state_nx_s = DONE;
          if (owner_r) begin
            ack1_nx_s   = 1'b1;
            err1_nx_s   = 1'b1;
            rdata1_nx_s = {DATA_W{1'b0}};
          end else begin
            ack0_nx_s   = 1'b1;
            err0_nx_s   = 1'b1;
            rdata0_nx_s = {DATA_W{1'b0}};
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        // Hand priority to the other port so a waiting loser goes next.
        prio_nx_s  = ~owner_r;
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    // Box pins follow the state the FSM is about to enter.
    box_we_nx_s = (state_nx_s == ISSUE) &&  cmd_nx_s.we;
    box_re_nx_s = (state_nx_s == ISSUE) && !cmd_nx_s.we;
    if (state_nx_s == ISSUE || state_nx_s == WAIT_RD) begin
      box_addr_nx_s = cmd_nx_s.addr;
      box_wd_nx_s   = cmd_nx_s.wdata;
    end else begin
      box_addr_nx_s = {ADDR_W{1'b0}};
      box_wd_nx_s   = {DATA_W{1'b0}};
    end
    busy_nx_s = (state_nx_s != IDLE);
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_r    <= 1'b0;
      prio_r     <= 1'b0;
      cmd_r      <= '0;
      cnt_r      <= {CNT_W{1'b0}};
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      err0_r     <= 1'b0;
      err1_r     <= 1'b0;
      rdata0_r   <= {DATA_W{1'b0}};
      rdata1_r   <= {DATA_W{1'b0}};
      box_re_r   <= 1'b0;
      box_we_r   <= 1'b0;
      box_wd_r   <= {DATA_W{1'b0}};
      box_addr_r <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      owner_r    <= owner_nx_s;
      prio_r     <= prio_nx_s;
      cmd_r      <= cmd_nx_s;
      cnt_r      <= cnt_nx_s;
      ack0_r     <= ack0_nx_s;
      ack1_r     <= ack1_nx_s;
      err0_r     <= err0_nx_s;
      err1_r     <= err1_nx_s;
      rdata0_r   <= rdata0_nx_s;
      rdata1_r   <= rdata1_nx_s;
      box_re_r   <= box_re_nx_s;
      box_we_r   <= box_we_nx_s;
      box_wd_r   <= box_wd_nx_s;
      box_addr_r <= box_addr_nx_s;
      busy_r     <= busy_nx_s;
    end
  end

  assign ack0             = ack0_r;
  assign ack1             = ack1_r;
  assign err0             = err0_r;
  assign err1             = err1_r;
  assign rdata0           = rdata0_r;
  assign rdata1           = rdata1_r;
  assign box_read_enable  = box_re_r;
  assign box_write_enable = box_we_r;
  assign box_write_data   = box_wd_r;
  assign box_address      = box_addr_r;
  assign busy             = busy_r;

endmodule
